// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: opcode encodings,
// default latencies and the FSM state type.
package md_pkg;

  localparam logic [2:0] MDOP_MULT  = 3'b000;
  localparam logic [2:0] MDOP_MULTU = 3'b001;
  localparam logic [2:0] MDOP_DIV   = 3'b010;
  localparam logic [2:0] MDOP_DIVU  = 3'b011;
  localparam logic [2:0] MDOP_MTHI  = 3'b100;
  localparam logic [2:0] MDOP_MTLO  = 3'b101;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_t;

  // Multi-cycle ops (mult/multu/div/divu) are the ones that occupy the unit.
  function automatic logic is_long_op(input logic [2:0] op);
    return (op <= MDOP_DIVU);
  endfunction

endpackage

// File: rtl/md_core.sv
// Combinational arithmetic for the md unit: 32x32 products and 32/32
// quotient/remainder, packed as {res_hi, res_lo} the way HI/LO expect them.
module md_core
  import md_pkg::*;
(
  input  logic [2:0]  mdop,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] dq;
  logic [31:0] dr;
  logic [31:0] sq;
  logic [31:0] sr;
  logic        neg_a;
  logic        neg_b;

  assign div_zero = (rt_data == 32'd0);

  // Signed division goes through magnitudes so truncation toward zero and
  // the dividend-signed remainder fall out without signed-divide corner cases;
  // 0x80000000 / -1 wraps naturally to 0x80000000.
  always_comb begin
    prod_s = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
    prod_u = {32'd0, rs_data} * {32'd0, rt_data};
    neg_a  = rs_data[31];
    neg_b  = rt_data[31];
    mag_a  = neg_a ? (~rs_data + 32'd1) : rs_data;
    mag_b  = neg_b ? (~rt_data + 32'd1) : rt_data;
    uq     = 32'd0;
    ur     = 32'd0;
    dq     = 32'd0;
    dr     = 32'd0;
    if (!div_zero) begin
      uq = mag_a / mag_b;
      ur = mag_a % mag_b;
      dq = rs_data / rt_data;
      dr = rs_data % rt_data;
    end
    sq = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
    sr = neg_a ? (~ur + 32'd1) : ur;

    res_hi = 32'd0;
    res_lo = 32'd0;
    case (mdop)
      MDOP_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      MDOP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      MDOP_DIV: begin
        res_hi = sr;
        res_lo = sq;
      end
      MDOP_DIVU: begin
        res_hi = dr;
        res_lo = dq;
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// EX-stage multiply/divide sequencer: latches the result at start, counts out
// the fixed latency, then commits to HI/LO; owns HI/LO and the md stall request.
module md_ctrl
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        md_use_d,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_t   state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [31:0] res_hi_q, res_hi_n;
  logic [31:0] res_lo_q, res_lo_n;
  logic        pend_zero, pend_zero_n;
  logic [31:0] hi_n, lo_n;
  logic [31:0] core_hi;
  logic [31:0] core_lo;
  logic        core_div_zero;

  md_core u_core (
    .mdop     (mdop),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .res_hi   (core_hi),
    .res_lo   (core_lo),
    .div_zero (core_div_zero)
  );

  // A divide-by-zero still runs its full latency; only the commit is dropped.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    res_hi_n    = res_hi_q;
    res_lo_n    = res_lo_q;
    pend_zero_n = pend_zero;
    hi_n        = hi;
    lo_n        = lo;
    case (state)
      ST_IDLE: begin
        if (start) begin
          case (mdop)
            MDOP_MULT, MDOP_MULTU: begin
              res_hi_n    = core_hi;
              res_lo_n    = core_lo;
              pend_zero_n = 1'b0;
              cnt_n       = 4'(MULT_CYCLES);
              state_n     = ST_RUN;
            end
            MDOP_DIV, MDOP_DIVU: begin
              res_hi_n    = core_hi;
              res_lo_n    = core_lo;
              pend_zero_n = core_div_zero;
              cnt_n       = 4'(DIV_CYCLES);
              state_n     = ST_RUN;
            end
            MDOP_MTHI: hi_n = rs_data;
            MDOP_MTLO: lo_n = rs_data;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (cnt == 4'd1) begin
          cnt_n   = 4'd0;
          state_n = ST_IDLE;
          if (!pend_zero) begin
            hi_n = res_hi_q;
            lo_n = res_lo_q;
          end
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      res_hi_q  <= 32'd0;
      res_lo_q  <= 32'd0;
      pend_zero <= 1'b0;
      hi        <= 32'd0;
      lo        <= 32'd0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      res_hi_q  <= res_hi_n;
      res_lo_q  <= res_lo_n;
      pend_zero <= pend_zero_n;
      hi        <= hi_n;
      lo        <= lo_n;
    end
  end

  assign busy     = (state == ST_RUN);
  assign stall_md = md_use_d & (busy | (start & is_long_op(mdop)));

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: a cycle-level reference model of the
// HI/LO/busy behaviour checked every cycle, plus directed literal checks.
module tb_md_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  mdop;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        md_use_d;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  md_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mdop     (mdop),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .md_use_d (md_use_d),
    .busy     (busy),
    .stall_md (stall_md),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: remaining busy cycles plus the pending {hi,lo} result.
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  logic        m_pwrite;
  int          m_rem;
  logic        m_valid = 1'b0;

  always @(posedge clk) begin
    longint      sq, sr;
    logic [63:0] p;
    if (!reset) begin
      m_hi = 0; m_lo = 0; m_rem = 0; m_pwrite = 0; m_valid = 1'b1;
    end else if (m_rem > 0) begin
      if (m_rem == 1 && m_pwrite) begin
        m_hi = m_phi; m_lo = m_plo;
      end
      m_rem = m_rem - 1;
    end else if (start) begin
      case (mdop)
        3'd0: begin
          p = 64'(longint'($signed(rs_data)) * longint'($signed(rt_data)));
          m_phi = p[63:32]; m_plo = p[31:0]; m_pwrite = 1; m_rem = 5;
        end
        3'd1: begin
          p = {32'd0, rs_data} * {32'd0, rt_data};
          m_phi = p[63:32]; m_plo = p[31:0]; m_pwrite = 1; m_rem = 5;
        end
        3'd2: begin
          m_rem = 10; m_pwrite = (rt_data != 0);
          if (m_pwrite) begin
            sq = longint'($signed(rs_data)) / longint'($signed(rt_data));
            sr = longint'($signed(rs_data)) % longint'($signed(rt_data));
            m_plo = sq[31:0]; m_phi = sr[31:0];
          end
        end
        3'd3: begin
          m_rem = 10; m_pwrite = (rt_data != 0);
          if (m_pwrite) begin
            m_plo = rs_data / rt_data; m_phi = rs_data % rt_data;
          end
        end
        3'd4: m_hi = rs_data;
        3'd5: m_lo = rs_data;
        default: ;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (m_valid && reset) begin
      checkOutput("model_busy", {31'd0, busy}, {31'd0, m_rem > 0});
      checkOutput("model_hi", hi, m_hi);
      checkOutput("model_lo", lo, m_lo);
      checkOutput("model_stall", {31'd0, stall_md},
                  {31'd0, md_use_d & ((m_rem > 0) | (start & (mdop <= 3'd3)))});
    end
  end

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; mdop = op; rs_data = a; rt_data = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic countBusy(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic runOp(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int cyc, input logic [31:0] ehi,
                       input logic [31:0] elo);
    int n;
    applyStimulus(op, a, b);
    countBusy(n);
    checkOutput({name, "_cycles"}, 32'(n), 32'(cyc));
    checkOutput({name, "_hi"}, hi, ehi);
    checkOutput({name, "_lo"}, lo, elo);
  endtask

  initial begin
    int n;
    reset = 1'b0; start = 1'b0; mdop = 3'd0; rs_data = 0; rt_data = 0; md_use_d = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_hi", hi, 32'd0);
    checkOutput("reset_lo", lo, 32'd0);

    runOp("mult", 3'd0, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    runOp("multu", 3'd1, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE);
    runOp("div", 3'd2, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    runOp("divu", 3'd3, 32'hFFFFFFF9, 32'd2, 10, 32'h00000001, 32'h7FFFFFFC);
    runOp("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);
    runOp("div_pos_neg", 3'd2, 32'd7, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD);

    applyStimulus(3'd4, 32'h11, 32'd0);
    checkOutput("mthi_hi", hi, 32'h11);
    checkOutput("mthi_busy", {31'd0, busy}, 32'd0);
    applyStimulus(3'd5, 32'h22, 32'd0);
    checkOutput("mtlo_lo", lo, 32'h22);
    runOp("divu_zero", 3'd3, 32'd100, 32'd0, 10, 32'h11, 32'h22);

    applyStimulus(3'd6, 32'h55, 32'h66);
    checkOutput("nop_busy", {31'd0, busy}, 32'd0);
    checkOutput("nop_hi", hi, 32'h11);

    // Stall across a mult, including the start cycle.
    md_use_d = 1'b1;
    start = 1'b1; mdop = 3'd0; rs_data = 32'd3; rt_data = 32'd4;
    #1 checkOutput("stall_start", {31'd0, stall_md}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_busy", {31'd0, stall_md}, 32'd1);
      @(posedge clk); #1;
    end
    checkOutput("stall_after", {31'd0, stall_md}, 32'd0);
    checkOutput("stall_lo", lo, 32'd12);
    md_use_d = 1'b0;

    // A start during RUN must not disturb the in-flight op.
    applyStimulus(3'd1, 32'd6, 32'd7);
    applyStimulus(3'd1, 32'd100, 32'd100);
    countBusy(n);
    checkOutput("ignore_cycles", 32'(n), 32'd4);
    checkOutput("ignore_lo", lo, 32'd42);
    checkOutput("ignore_hi", hi, 32'd0);

    // Back-to-back start in the first idle cycle.
    runOp("b2b", 3'd0, 32'd5, 32'd5, 5, 32'd0, 32'd25);

    // Reset during the third busy cycle of a div aborts it.
    applyStimulus(3'd3, 32'd50, 32'd7);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_hi", hi, 32'd0);
    checkOutput("abort_lo", lo, 32'd0);
    repeat (12) @(posedge clk);
    #1 checkOutput("abort_nowrite", lo, 32'd0);
    applyStimulus(3'd5, 32'h1234, 32'd0);
    checkOutput("post_reset_mtlo", lo, 32'h1234);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
